// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, ARM condition codes, NZCV bit positions
// and the condition/compare helpers used by the issue controller.
//
// ALU flag semantics: N = result MSB, Z = result is zero. Arithmetic ops give
// the adder carry-out as C (for subtracts that is NOT borrow) and the signed
// overflow as V. Logical ops pass carry-in through as C and give V = 0.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } alu_op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  localparam int NEG = 3;
  localparam int ZER = 2;
  localparam int CAR = 1;
  localparam int OVR = 0;

  // ARM condition-code evaluation against an NZCV nibble.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n;
    logic z;
    logic c;
    logic v;
    logic ok;
    n = nzcv[NEG];
    z = nzcv[ZER];
    c = nzcv[CAR];
    v = nzcv[OVR];
    ok = 1'b0;
    case (cond_e'(cond))
      COND_EQ: ok = z;
      COND_NE: ok = !z;
      COND_CS: ok = c;
      COND_CC: ok = !c;
      COND_MI: ok = n;
      COND_PL: ok = !n;
      COND_VS: ok = v;
      COND_VC: ok = !v;
      COND_HI: ok = c && !z;
      COND_LS: ok = !c || z;
      COND_GE: ok = (n == v);
      COND_LT: ok = (n != v);
      COND_GT: ok = !z && (n == v);
      COND_LE: ok = z || (n != v);
      COND_AL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // TST/TEQ/CMP/CMN: always update flags, never write a register.
  function automatic logic is_compare(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ARM-style data-processing ALU (no shifter).
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry,
  input  logic [3:0]       opcode,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags
);

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             arith;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH:0]   sum;
  logic             c_out;
  logic             v_out;

  // Select adder operands (subtracts as x + ~y + cin) or a logical result.
  always_comb begin
    x         = a;
    y         = b;
    cin       = 1'b0;
    arith     = 1'b0;
    logic_res = '0;
    case (alu_op_e'(opcode))
      OP_AND, OP_TST: logic_res = a & b;
      OP_EOR, OP_TEQ: logic_res = a ^ b;
      OP_ORR:         logic_res = a | b;
      OP_MOV:         logic_res = b;
      OP_BIC:         logic_res = a & ~b;
      OP_MVN:         logic_res = ~b;
      OP_SUB, OP_CMP: begin x = a; y = ~b; cin = 1'b1;  arith = 1'b1; end
      OP_RSB:         begin x = b; y = ~a; cin = 1'b1;  arith = 1'b1; end
      OP_ADD, OP_CMN: begin x = a; y = b;  cin = 1'b0;  arith = 1'b1; end
      OP_ADC:         begin x = a; y = b;  cin = carry; arith = 1'b1; end
      OP_SBC:         begin x = a; y = ~b; cin = carry; arith = 1'b1; end
      OP_RSC:         begin x = b; y = ~a; cin = carry; arith = 1'b1; end
      default:        logic_res = '0;
    endcase
  end

  // Shared adder plus result/flag formation.
  always_comb begin
    sum   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    out   = arith ? sum[WIDTH-1:0] : logic_res;
    c_out = arith ? sum[WIDTH] : carry;
    v_out = arith && (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    flags = {out[WIDTH-1], (out == '0), c_out, v_out};
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller around the ALU: condition check against the owned NZCV
// register, single-entry registered result stage, executed/skipped counters.
//
// Handshake: a transfer occurs on a clock edge where valid && ready are both
// high. A requester keeps valid and its payload stable until that edge; the
// result stage keeps res_* stable while res_valid && !res_ready. req_ready is
// combinational on res_ready (a full stage can be refilled as it drains).
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [3:0]       req_cond,
  input  logic             req_s,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_rd,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [TAG_W-1:0] res_rd,
  output logic             res_wr,
  input  logic             flag_load,
  input  logic [3:0]       flag_load_val,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] skip_cnt
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       alu_flags;
  logic             cond_ok;
  logic             cmp_op;
  logic             accept;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a      (req_a),
    .b      (req_b),
    .carry  (flags_q[CAR]),
    .opcode (req_op),
    .out    (alu_out),
    .flags  (alu_flags)
  );

  assign cond_ok   = cond_pass(req_cond, flags_q);
  assign cmp_op    = is_compare(req_op);
  assign req_ready = (state == ST_EMPTY) || res_ready;
  assign accept    = req_valid && req_ready;
  // The output-stage state bit is the result-valid flag itself.
  assign res_valid = (state == ST_FULL);

  // Result stage: load on accept, drain when the consumer takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_EMPTY;
      res_data <= '0;
      res_rd   <= '0;
      res_wr   <= 1'b0;
    end else if (accept) begin
      state    <= ST_FULL;
      res_data <= alu_out;
      res_rd   <= req_rd;
      res_wr   <= cond_ok && !cmp_op;
    end else if (res_ready) begin
      state    <= ST_EMPTY;
    end
  end

  // NZCV: direct load has priority over an ALU flag update in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= 4'h0;
    end else if (flag_load) begin
      flags_q <= flag_load_val;
    end else if (accept && cond_ok && (req_s || cmp_op)) begin
      flags_q <= alu_flags;
    end
  end

  // Saturating counters of executed and skipped (condition-failed) ops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exec_cnt <= '0;
      skip_cnt <= '0;
    end else if (accept) begin
      if (cond_ok) begin
        if (exec_cnt != {CNT_W{1'b1}}) exec_cnt <= exec_cnt + 1'b1;
      end else begin
        if (skip_cnt != {CNT_W{1'b1}}) skip_cnt <= skip_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural model + per-cycle compare, result
// scoreboard, directed literal checks and randomized traffic.
module tb_alu_issue_ctrl;

  localparam int W    = 32;
  localparam int TW   = 4;
  localparam int CW   = 4;
  localparam int SB_W = W + TW + 1;

  logic          clk;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [3:0]    req_cond;
  logic          req_s;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic [TW-1:0] req_rd;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic [TW-1:0] res_rd;
  logic          res_wr;
  logic          flag_load;
  logic [3:0]    flag_load_val;
  logic [3:0]    flags_q;
  logic [CW-1:0] exec_cnt;
  logic [CW-1:0] skip_cnt;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  alu_issue_ctrl #(.WIDTH(W), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_cond(req_cond), .req_s(req_s), .req_a(req_a), .req_b(req_b),
    .req_rd(req_rd), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_rd(res_rd), .res_wr(res_wr),
    .flag_load(flag_load), .flag_load_val(flag_load_val), .flags_q(flags_q),
    .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // ALU computed with wide signed/unsigned integer arithmetic.
  function automatic void model_alu(input logic [3:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic c,
                                    output logic [W-1:0] r, output logic [3:0] f);
    longint ua, ub, uc, sa, sb, u, s;
    logic arith, is_sub, cf, vf;
    ua = longint'(a); ub = longint'(b); uc = c ? 64'sd1 : 64'sd0;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    arith = 1'b1; is_sub = 1'b0; u = 0; s = 0; r = '0;
    case (op)
      4'h0, 4'h8: begin r = a & b;  arith = 1'b0; end
      4'h1, 4'h9: begin r = a ^ b;  arith = 1'b0; end
      4'hC:       begin r = a | b;  arith = 1'b0; end
      4'hD:       begin r = b;      arith = 1'b0; end
      4'hE:       begin r = a & ~b; arith = 1'b0; end
      4'hF:       begin r = ~b;     arith = 1'b0; end
      4'h2, 4'hA: begin u = ua - ub; s = sa - sb; is_sub = 1'b1; end
      4'h3:       begin u = ub - ua; s = sb - sa; is_sub = 1'b1; end
      4'h4, 4'hB: begin u = ua + ub; s = sa + sb; end
      4'h5:       begin u = ua + ub + uc; s = sa + sb + uc; end
      4'h6:       begin u = ua - ub - (1 - uc); s = sa - sb - (1 - uc); is_sub = 1'b1; end
      default:    begin u = ub - ua - (1 - uc); s = sb - sa - (1 - uc); is_sub = 1'b1; end
    endcase
    if (arith) begin
      r  = u[W-1:0];
      cf = is_sub ? (u >= 0) : (u > 64'sd4294967295);
      vf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else begin
      cf = c;
      vf = 1'b0;
    end
    f = {r[W-1], (r == '0), cf, vf};
  endfunction

  function automatic logic model_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic          m_valid = 1'b0;
  logic [W-1:0]  m_data  = '0;
  logic [TW-1:0] m_rd    = '0;
  logic          m_wr    = 1'b0;
  logic [3:0]    m_flags = 4'h0;
  int            m_exec  = 0;
  int            m_skip  = 0;
  logic [SB_W-1:0] exp_q[$];

  logic [W-1:0] mr;
  logic [3:0]   mf, nf;
  logic         m_acc, m_ok, m_cmp;

  // Model steps on every clock edge; reset empties it and the scoreboard.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid = 1'b0; m_data = '0; m_rd = '0; m_wr = 1'b0;
      m_flags = 4'h0; m_exec = 0; m_skip = 0;
      exp_q.delete();
    end else begin
      m_acc = req_valid && (!m_valid || res_ready);
      nf = m_flags;
      if (m_acc) begin
        model_alu(req_op, req_a, req_b, m_flags[1], mr, mf);
        m_ok  = model_cond(req_cond, m_flags);
        m_cmp = (req_op >= 4'h8) && (req_op <= 4'hB);
        m_data = mr; m_rd = req_rd; m_wr = m_ok && !m_cmp; m_valid = 1'b1;
        if (m_ok && (req_s || m_cmp)) nf = mf;
        if (m_ok) m_exec = (m_exec < (1 << CW) - 1) ? m_exec + 1 : m_exec;
        else      m_skip = (m_skip < (1 << CW) - 1) ? m_skip + 1 : m_skip;
        exp_q.push_back({mr, req_rd, m_ok && !m_cmp});
      end else if (res_ready) begin
        m_valid = 1'b0;
      end
      if (flag_load) nf = flag_load_val;
      m_flags = nf;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("res_valid", res_valid, m_valid);
      check("req_ready", req_ready, !m_valid || res_ready);
      check("flags_q", flags_q, m_flags);
      check("exec_cnt", exec_cnt, m_exec[CW-1:0]);
      check("skip_cnt", skip_cnt, m_skip[CW-1:0]);
      if (m_valid) begin
        check("res_data", res_data, m_data);
        check("res_rd", res_rd, m_rd);
        check("res_wr", res_wr, m_wr);
      end
    end
  end

  // Scoreboard: each consumed result must be the next one issued.
  logic [SB_W-1:0] sb;
  always @(negedge clk) begin
    if (chk_en && reset_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_extra: unexpected result data=%0h rd=%0h", res_data, res_rd);
      end else begin
        sb = exp_q.pop_front();
        check("sb_data", res_data, sb[SB_W-1:TW+1]);
        check("sb_rd", res_rd, sb[TW:1]);
        check("sb_wr", res_wr, sb[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] cond, input logic s,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] rd);
    int n;
    logic acc;
    n = 0; acc = 1'b0;
    req_op = op; req_cond = cond; req_s = s; req_a = a; req_b = b; req_rd = rd;
    req_valid = 1'b1;
    while (!acc) begin
      #1;
      acc = req_ready;
      @(posedge clk);
      #1;
      if (!acc) begin
        n++;
        if (n > 40) begin
          total++; bad++;
          $display("FAIL send_timeout: req_ready=%0b required 1", req_ready);
          acc = 1'b1;
        end
      end
    end
    req_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return W'($urandom_range(0, 3));
      1:       return 32'hFFFF_FFFF - W'($urandom_range(0, 3));
      2:       return 32'h7FFF_FFFF + W'($urandom_range(0, 2));
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_op = 4'h0; req_cond = 4'hE; req_s = 1'b0;
    req_a = '0; req_b = '0; req_rd = '0; res_ready = 1'b1;
    flag_load = 1'b0; flag_load_val = 4'h0;
    @(posedge clk);
    chk_en = 1'b1;
    tick(); tick();
    check("rst_valid", res_valid, 0);
    check("rst_flags", flags_q, 4'h0);
    check("rst_ready", req_ready, 1);
    check("rst_exec", exec_cnt, 0);
    check("rst_skip", skip_cnt, 0);
    reset_n = 1'b1;
    tick();

    // ADD AL s=1 7+5
    send(4'h4, 4'hE, 1'b1, 32'd7, 32'd5, 4'd3);
    check("add_valid", res_valid, 1);
    check("add_data", res_data, 32'd12);
    check("add_rd", res_rd, 4'd3);
    check("add_wr", res_wr, 1);
    check("add_flags", flags_q, 4'b0000);
    check("add_exec", exec_cnt, 1);

    // SUB s=1 5-5 -> Z,C; then ADD EQ; then ADD NE
    send(4'h2, 4'hE, 1'b1, 32'd5, 32'd5, 4'd1);
    check("sub_flags", flags_q, 4'b0110);
    send(4'h4, 4'h0, 1'b0, 32'd1, 32'd2, 4'd2);
    check("eq_data", res_data, 32'd3);
    check("eq_wr", res_wr, 1);
    send(4'h4, 4'h1, 1'b1, 32'd9, 32'd9, 4'd4);
    check("ne_wr", res_wr, 0);
    check("ne_flags", flags_q, 4'b0110);
    check("ne_skip", skip_cnt, 1);
    check("ne_exec", exec_cnt, 3);

    // Clear flags, CMP s=0 forces update, AND s=0 leaves flags alone
    flag_load = 1'b1; flag_load_val = 4'h0;
    tick();
    flag_load = 1'b0;
    check("fl_clear", flags_q, 4'h0);
    send(4'hA, 4'hE, 1'b0, 32'd3, 32'd3, 4'd5);
    check("cmp_wr", res_wr, 0);
    check("cmp_flags", flags_q, 4'b0110);
    send(4'h0, 4'hE, 1'b0, 32'hF0, 32'h0F, 4'd6);
    check("and_data", res_data, 32'd0);
    check("and_flags", flags_q, 4'b0110);

    // Backpressure
    tick();
    res_ready = 1'b0;
    send(4'h4, 4'hE, 1'b0, 32'd10, 32'd20, 4'd7);
    req_op = 4'h2; req_cond = 4'hE; req_s = 1'b0; req_a = 32'd100; req_b = 32'd1; req_rd = 4'd8;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready", req_ready, 0);
      check("bp_data", res_data, 32'd30);
      check("bp_valid", res_valid, 1);
      tick();
    end
    res_ready = 1'b1;
    #1;
    check("bp_release", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("bp_second", res_data, 32'd99);
    check("bp_rd", res_rd, 4'd8);

    // flag_load beats simultaneous SUB s=1
    flag_load = 1'b1; flag_load_val = 4'b1001;
    send(4'h2, 4'hE, 1'b1, 32'd5, 32'd5, 4'd2);
    flag_load = 1'b0;
    check("fl_win", flags_q, 4'b1001);
    check("fl_data", res_data, 32'd0);
    check("fl_wr", res_wr, 1);

    // Asynchronous reset while FULL
    send(4'h4, 4'hE, 1'b1, 32'd1, 32'd1, 4'd9);
    res_ready = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_valid", res_valid, 0);
    check("arst_flags", flags_q, 4'h0);
    check("arst_exec", exec_cnt, 0);
    tick(); tick();
    reset_n = 1'b1;
    res_ready = 1'b1;
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      req_valid     = ($urandom_range(0, 99) < 70);
      req_op        = 4'($urandom_range(0, 15));
      req_cond      = 4'($urandom_range(0, 15));
      req_s         = 1'($urandom_range(0, 1));
      req_a         = rand_val();
      req_b         = rand_val();
      req_rd        = 4'($urandom_range(0, 15));
      res_ready     = ($urandom_range(0, 99) < 75);
      flag_load     = ($urandom_range(0, 99) < 8);
      flag_load_val = 4'($urandom_range(0, 15));
      tick();
    end
    req_valid = 1'b0; flag_load = 1'b0; res_ready = 1'b1;
    tick(); tick();

    // Counter saturation
    for (int i = 0; i < 20; i++) send(4'hD, 4'hE, 1'b0, 32'd0, 32'(i), 4'd1);
    check("exec_sat", exec_cnt, 4'hF);
    for (int i = 0; i < 20; i++) send(4'hD, 4'hF, 1'b0, 32'd0, 32'(i), 4'd1);
    check("skip_sat", skip_cnt, 4'hF);
    check("skip_exec_hold", exec_cnt, 4'hF);

    tick(); tick();
    check("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/sequencing controller wrapped around the existing combinational `alu` (ports a, b, carry, opcode, out, flags).
- Accepts one ALU operation per cycle over a valid/ready handshake and evaluates the ARM condition code against the architectural NZCV register it owns.
- Drives the ALU with the C flag as carry-in, updates NZCV on S-suffixed or compare ops, and presents a registered result with a register-writeback qualifier.
- Sits between decode and register-file writeback.

Parameters:
- WIDTH, 32, data width of operands and result.
- TAG_W, 4, destination-register tag width.
- CNT_W, 16, width of the saturating executed/skipped counters.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept
- req_op  in  4  ALU opcode (0 AND … F MVN; 8–B = TST/TEQ/CMP/CMN)
- req_cond  in  4  ARM condition code
- req_s  in  1  set-flags bit
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- req_rd  in  TAG_W  destination tag
- res_valid  out  1  result present
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  registered ALU out
- res_rd  out  TAG_W  registered tag
- res_wr  out  1  writeback enable for res_data
- flag_load  in  1  direct NZCV load (MSR-style)
- flag_load_val  in  4  value for flag_load
- flags_q  out  4  current NZCV; [3]=N [2]=Z [1]=C [0]=V
- exec_cnt  out  CNT_W  ops whose condition passed
- skip_cnt  out  CNT_W  ops whose condition failed

Behaviour:
- Reset (async assert, sync-safe deassert): res_valid=0, res_data=0, res_rd=0, res_wr=0, flags_q=0, exec_cnt=0, skip_cnt=0. Reset mid-operation discards the held result; no partial flag update.
- Output stage is a single register with two states, EMPTY and FULL.
  - req_ready = (state==EMPTY) || res_ready. This is combinational on res_ready; there is no skid buffer.
  - Accept happens when req_valid && req_ready. On accept the state becomes or stays FULL.
  - When FULL, res_ready=1 and no accept: go to EMPTY.
  - When FULL and res_ready=0: res_data, res_rd, res_wr, res_valid are held stable.
- ALU drive: a=req_a, b=req_b, opcode=req_op, carry=flags_q[1]. Evaluated combinationally in the accept cycle.
- Latency: result visible one cycle after accept.
- Condition pass (cond_ok):
  - 0 EQ: Z. 1 NE: !Z. 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N. 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z. A GE: N==V. B LT: N!=V.
  - C GT: !Z&(N==V). D LE: Z|(N!=V). E AL: 1. F: 0 (never).
- On accept:
  - res_data=alu out (always, even if cond fails).
  - res_rd=req_rd.
  - res_wr = cond_ok && !(req_op in 8..B).
  - flags_q <= alu flags when cond_ok && (req_s || req_op in 8..B); otherwise unchanged.
  - exec_cnt++ if cond_ok, else skip_cnt++. Both saturate at all-ones.
- Back-to-back ops: a flag update lands on the accept edge, so the next accepted op's condition and carry see it. No bubble.
- flag_load=1 loads flags_q=flag_load_val on that edge and wins over a simultaneous ALU flag update. The simultaneous op's result and res_wr are otherwise unaffected.
- Without accept, flags_q changes only via flag_load.

Decomposition:
- Shared package `alu_pkg`:
  - opcode enum (AND..MVN)
  - condition enum (EQ..NV)
  - flag bit indices NEG=3, ZER=2, CAR=1, OVR=0
  - function `cond_pass(cond, nzcv)`
  - function `is_compare(op)`
- One sub-module instance: the existing `alu`.
- Condition evaluation stays a package function, not a module.

Test Plan:
- Reset: hold reset_n=0 -> res_valid=0, flags_q=4'h0, req_ready=1, exec_cnt=skip_cnt=0. Assert reset_n=0 while FULL -> res_valid drops immediately.
- ADD (4), cond AL (E), s=1, a=7, b=5, rd=3 -> next cycle res_valid=1, res_data=12, res_rd=3, res_wr=1, flags_q N=0 Z=0, exec_cnt=1.
- SUB (2) s=1, a=5, b=5 -> Z=1. Then back-to-back ADD cond EQ (a=1, b=2) -> res_data=3, res_wr=1. Then ADD cond NE -> res_wr=0, flags_q unchanged, skip_cnt=1.
- CMP (A) s=0, a=3, b=3 -> res_wr=0, flags_q[2]=1 (compare forces update). Then AND s=0 -> flags_q unchanged.
- Backpressure: res_ready=0 after first result, second request offered -> req_ready=0 and res_data stable for 5 cycles. res_ready=1 -> second result appears the following cycle, none lost or duplicated.
- flag_load=1, flag_load_val=4'b1001 in the same cycle as an accepted SUB s=1 (5-5) -> flags_q=4'b1001, while res_data=0 and res_wr=1.
